// File: rtl/dram_port_arbiter.sv
// Shares one synchronous RAM port between the data (d_*) and fetch (i_*) requesters.
// Optional `ARB_RR_EN: alternate the grant on contention instead of fixed data priority.
module dram_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [DATA_W/8-1:0] d_ren,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_busy,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_wdone,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_busy,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                err
);
  localparam int STRB_W = DATA_W / 8;

  logic              d_pulse;
  logic              d_cand;
  logic              i_cand;
  logic              d_first;
  logic              grant_d;
  logic              grant_i;

  logic              d_slot_vld_q, d_slot_vld_d;
  logic [STRB_W-1:0] d_slot_we_q, d_slot_we_d;
  logic [ADDR_W-1:0] d_slot_addr_q, d_slot_addr_d;
  logic [DATA_W-1:0] d_slot_wdata_q, d_slot_wdata_d;
  logic              i_slot_vld_q, i_slot_vld_d;
  logic [ADDR_W-1:0] i_slot_addr_q, i_slot_addr_d;

  logic              err_q, err_d;
  logic              ram_en_q, ram_en_d;
  logic [STRB_W-1:0] ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              d_wdone_q, d_wdone_d;
  logic              ram_own_q, ram_own_d;

  logic [RAM_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RAM_LAT-1:0] tag_own_q, tag_own_d;

`ifdef ARB_RR_EN
  logic last_d_q, last_d_d;

  always_comb begin
    last_d_d = ram_en_d ? grant_d : last_d_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  always_comb begin
    d_pulse = (|d_ren) | (|d_wen);

    // A full slot is always the candidate; otherwise the incoming pulse is.
    d_cand         = d_slot_vld_q | d_pulse;
    d_slot_we_d    = d_slot_vld_q ? d_slot_we_q    : d_wen;
    d_slot_addr_d  = d_slot_vld_q ? d_slot_addr_q  : d_addr;
    d_slot_wdata_d = d_slot_vld_q ? d_slot_wdata_q : d_wdata;
    i_cand         = i_slot_vld_q | i_req;
    i_slot_addr_d  = i_slot_vld_q ? i_slot_addr_q  : i_addr;

`ifdef ARB_RR_EN
    d_first = ~last_d_q;
`else
    d_first = 1'b1;
`endif
    grant_d = d_cand & (d_first | ~i_cand);
    grant_i = i_cand & ~grant_d;

    d_slot_vld_d = d_cand & ~grant_d;
    i_slot_vld_d = i_cand & ~grant_i;

    err_d = err_q
          | ((|d_ren) & (|d_wen))
          | (d_pulse & d_slot_vld_q)
          | (i_req & i_slot_vld_q);

    ram_en_d    = grant_d | grant_i;
    ram_we_d    = grant_d ? d_slot_we_d : '0;
    ram_addr_d  = grant_d ? d_slot_addr_d : (grant_i ? i_slot_addr_d : ram_addr_q);
    ram_wdata_d = grant_d ? d_slot_wdata_d : ram_wdata_q;
    d_wdone_d   = grant_d & (|d_slot_we_d);
    ram_own_d   = grant_d;

    // The issue register acts as stage 0, so a tag leaves the pipe RAM_LAT cycles after ram_en.
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = ram_en_q & ~(|ram_we_q);
    tag_own_d[0] = ram_own_q;
    for (int k = 1; k < RAM_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_own_d[k] = tag_own_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_slot_vld_q <= 1'b0;
      i_slot_vld_q <= 1'b0;
      err_q        <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      d_wdone_q    <= 1'b0;
      ram_own_q    <= 1'b0;
      tag_vld_q    <= '0;
      tag_own_q    <= '0;
    end else begin
      d_slot_vld_q <= d_slot_vld_d;
      i_slot_vld_q <= i_slot_vld_d;
      err_q        <= err_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      d_wdone_q    <= d_wdone_d;
      ram_own_q    <= ram_own_d;
      tag_vld_q    <= tag_vld_d;
      tag_own_q    <= tag_own_d;
    end
  end

  // Slot payloads are qualified by the valid flags, so they need no reset.
  always_ff @(posedge clk) begin
    d_slot_we_q    <= d_slot_we_d;
    d_slot_addr_q  <= d_slot_addr_d;
    d_slot_wdata_q <= d_slot_wdata_d;
    i_slot_addr_q  <= i_slot_addr_d;
  end

  assign d_busy    = d_slot_vld_q;
  assign i_busy    = i_slot_vld_q;
  assign err       = err_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign d_wdone   = d_wdone_q;

  assign d_rvalid = tag_vld_q[RAM_LAT-1] & tag_own_q[RAM_LAT-1];
  assign i_rvalid = tag_vld_q[RAM_LAT-1] & ~tag_own_q[RAM_LAT-1];
  assign d_rdata  = d_rvalid ? ram_rdata : '0;
  assign i_rdata  = i_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: vector table, directed multi-cycle sequences and
// random traffic against a timestamped-queue reference model with its own memory image.
module tb_dram_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic [3:0]        d_ren, d_wen;
  logic [31:0]       d_addr, d_wdata;
  logic              d_busy, d_rvalid, d_wdone;
  logic [31:0]       d_rdata;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_busy, i_rvalid;
  logic [31:0]       i_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [31:0]       ram_addr, ram_wdata, ram_rdata;
  logic              err;

  dram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_busy(d_busy), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_wdone(d_wdone),
    .i_req(i_req), .i_addr(i_addr), .i_busy(i_busy), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hashw(input int unsigned idx);
    return (idx * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Environment RAM: 256 words indexed by addr[9:2], LAT-cycle read pipe.
  logic [31:0] ram_mem [256];
  logic [31:0] rpipe [LAT];
  bit          ram_init_done = 1'b0;
  logic [15:0] gcnt = 16'h0;

  always @(posedge clk) begin
    gcnt <= gcnt + 16'h1;
    if (!ram_init_done) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= hashw(i);
      ram_init_done <= 1'b1;
    end else if (ram_en && ram_we != 4'h0) begin
      ram_mem[ram_addr[9:2]] <= merge(ram_mem[ram_addr[9:2]], ram_we, ram_wdata);
    end
    for (int k = LAT - 1; k > 0; k--) rpipe[k] <= rpipe[k-1];
    if (ram_en && ram_we == 4'h0) rpipe[0] <= ram_mem[ram_addr[9:2]];
    else                          rpipe[0] <= {16'hBAD0, gcnt};
  end
  assign ram_rdata = rpipe[LAT-1];

  // Reference model state
  typedef struct { int cyc; bit own_d; logic [31:0] data; } ret_t;
  ret_t        rq[$];
  logic [31:0] mmem [256];
  bit          m_dfull, m_ifull, m_err, m_last_d;
  logic [3:0]  m_dwe;
  logic [31:0] m_daddr, m_dwd, m_iaddr;
  bit          e_en, e_wdone, e_dbusy, e_ibusy, e_err, e_own_d;
  logic [3:0]  e_we;
  logic [31:0] e_addr, e_wdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    return mmem[a[9:2]];
  endfunction

  task automatic model_reset();
    rq.delete();
    m_dfull = 0; m_ifull = 0; m_err = 0; m_last_d = 0;
    e_en = 0; e_wdone = 0; e_dbusy = 0; e_ibusy = 0; e_err = 0; e_own_d = 0;
    e_we = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
  endtask

  // Predict the outputs of the next cycle from this cycle's inputs.
  task automatic model_step();
    bit dp, d_has, i_has, d_win, i_win;
    logic [3:0]  cwe;
    logic [31:0] caddr, cwd, ciaddr;
    dp = (d_ren != 4'h0) || (d_wen != 4'h0);
    if (d_ren != 4'h0 && d_wen != 4'h0) m_err = 1;
    d_has = m_dfull || dp;
    if (m_dfull) begin
      cwe = m_dwe; caddr = m_daddr; cwd = m_dwd;
      if (dp) m_err = 1;
    end else begin
      cwe = d_wen; caddr = d_addr; cwd = d_wdata;
    end
    i_has = m_ifull || i_req;
    if (m_ifull) begin
      ciaddr = m_iaddr;
      if (i_req) m_err = 1;
    end else begin
      ciaddr = i_addr;
    end
`ifdef ARB_RR_EN
    d_win = d_has && (!i_has || !m_last_d);
`else
    d_win = d_has;
`endif
    i_win = i_has && !d_win;
    e_en    = d_win || i_win;
    e_we    = d_win ? cwe : 4'h0;
    e_wdone = d_win && (cwe != 4'h0);
    if (d_win) begin
      e_addr = caddr; e_wdata = cwd; e_own_d = 1;
    end else if (i_win) begin
      e_addr = ciaddr; e_own_d = 0;
    end
    if (e_en) m_last_d = d_win;
    m_dfull = d_has && !d_win;
    m_dwe = cwe; m_daddr = caddr; m_dwd = cwd;
    m_ifull = i_has && !i_win;
    m_iaddr = ciaddr;
    e_dbusy = m_dfull; e_ibusy = m_ifull; e_err = m_err;
  endtask

  task automatic check_outputs();
    bit          ev_d, ev_i;
    logic [31:0] edat;
    ret_t        r;
    chk("ram_en", ram_en, e_en);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    if (e_en && e_we != 4'h0) chk("ram_wdata", ram_wdata, e_wdata);
    chk("d_wdone", d_wdone, e_wdone);
    chk("d_busy", d_busy, e_dbusy);
    chk("i_busy", i_busy, e_ibusy);
    chk("err", err, e_err);
    ev_d = 0; ev_i = 0; edat = 32'h0;
    while (rq.size() > 0 && rq[0].cyc <= cyc) begin
      r = rq.pop_front();
      if (r.cyc == cyc) begin
        ev_d = r.own_d; ev_i = !r.own_d; edat = r.data;
      end
    end
    chk("d_rvalid", d_rvalid, ev_d);
    chk("i_rvalid", i_rvalid, ev_i);
    chk("d_rdata", d_rdata, ev_d ? edat : 32'h0);
    chk("i_rdata", i_rdata, ev_i ? edat : 32'h0);
    if (e_en) begin
      if (e_we != 4'h0) mmem[e_addr[9:2]] = merge(mmem[e_addr[9:2]], e_we, e_wdata);
      else rq.push_back('{cyc + LAT, e_own_d, mread(e_addr)});
    end
  endtask

  task automatic cycle(input logic [3:0] dr, input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic ir, input logic [31:0] ia);
    check_outputs();
    d_ren = dr; d_wen = dw; d_addr = da; d_wdata = dwd; i_req = ir; i_addr = ia;
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    cycle(4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    d_ren = 4'h0; d_wen = 4'h0; d_addr = 32'h0; d_wdata = 32'h0; i_req = 1'b0; i_addr = 32'h0;
    #1;
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_busy", {d_busy, i_busy}, 0);
    chk("rst_rvalid", {d_rvalid, i_rvalid}, 0);
    chk("rst_rdata", {d_rdata, i_rdata}, 0);
    chk("rst_wdone_err", {d_wdone, err}, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [3:0] dr, dw; logic [31:0] da, dwd; logic ir; logic [31:0] ia;
    logic en; logic [3:0] we; logic [31:0] addr; logic db, ib, er, wd;
  } vec_t;
  vec_t        vt [9];
  logic [31:0] exp_seq [5];

  initial begin
    //           dr    dw    da         dwd           ir    ia       en    we    addr       db    ib    er    wd
    vt[0] = '{4'hF, 4'h0, 32'h100, 32'h0,        1'b0, 32'h0,  1'b1, 4'h0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{4'h0, 4'h3, 32'h40,  32'hDEADBEEF, 1'b0, 32'h0,  1'b1, 4'h3, 32'h40,  1'b0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{4'h0, 4'h0, 32'h0,   32'h0,        1'b0, 32'h0,  1'b0, 4'h0, 32'h40,  1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ARB_RR_EN
    vt[3] = '{4'hF, 4'h0, 32'h20,  32'h0,        1'b1, 32'h8,  1'b1, 4'h0, 32'h8,   1'b1, 1'b0, 1'b0, 1'b0};
    vt[4] = '{4'h0, 4'h0, 32'h0,   32'h0,        1'b0, 32'h0,  1'b1, 4'h0, 32'h20,  1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{4'h0, 4'h0, 32'h0,   32'h0,        1'b0, 32'h0,  1'b0, 4'h0, 32'h20,  1'b0, 1'b0, 1'b0, 1'b0};
    exp_seq = '{32'h180, 32'h280, 32'h184, 32'h288, 32'h18C};
`else
    vt[3] = '{4'hF, 4'h0, 32'h20,  32'h0,        1'b1, 32'h8,  1'b1, 4'h0, 32'h20,  1'b0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{4'h0, 4'h0, 32'h0,   32'h0,        1'b0, 32'h0,  1'b1, 4'h0, 32'h8,   1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{4'h0, 4'h0, 32'h0,   32'h0,        1'b0, 32'h0,  1'b0, 4'h0, 32'h8,   1'b0, 1'b0, 1'b0, 1'b0};
    exp_seq = '{32'h180, 32'h184, 32'h188, 32'h18C, 32'h280};
`endif
    vt[6] = '{4'h0, 4'h0, 32'h0,   32'h0,        1'b1, 32'h10, 1'b1, 4'h0, 32'h10,  1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{4'h1, 4'hC, 32'h44,  32'h11223344, 1'b0, 32'h0,  1'b1, 4'hC, 32'h44,  1'b0, 1'b0, 1'b1, 1'b1};
    vt[8] = '{4'h0, 4'h0, 32'h0,   32'h0,        1'b0, 32'h0,  1'b0, 4'h0, 32'h44,  1'b0, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 256; i++) mmem[i] = hashw(i);
    rstn = 1'b0;
    d_ren = 4'h0; d_wen = 4'h0; d_addr = 32'h0; d_wdata = 32'h0; i_req = 1'b0; i_addr = 32'h0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Vector table
    for (int i = 0; i < 9; i++) begin
      cycle(vt[i].dr, vt[i].dw, vt[i].da, vt[i].dwd, vt[i].ir, vt[i].ia);
      chk("vec_en", ram_en, vt[i].en);
      chk("vec_we", ram_we, vt[i].we);
      chk("vec_addr", ram_addr, vt[i].addr);
      chk("vec_busy", {d_busy, i_busy}, {vt[i].db, vt[i].ib});
      chk("vec_err", err, vt[i].er);
      chk("vec_wdone", d_wdone, vt[i].wd);
    end
    repeat (LAT + 2) idle();

    // Contended read routing: data first, then fetch, each with its own data
    do_reset();
    cycle(4'hF, 4'h0, 32'h20, 32'h0, 1'b1, 32'h8);
    for (int k = 1; k <= LAT + 3; k++) begin
      chk("rt_dvalid", d_rvalid, k == LAT + 1);
      chk("rt_ivalid", i_rvalid, k == LAT + 2);
      if (k == LAT + 1) chk("rt_ddata", d_rdata, mread(32'h20));
      if (k == LAT + 2) chk("rt_idata", i_rdata, mread(32'h8));
      idle();
    end

    // Reset one cycle after a read issues: the read never returns
    cycle(4'hF, 4'h0, 32'h100, 32'h0, 1'b0, 32'h0);
    idle();
    do_reset();
    for (int k = 0; k < LAT + 3; k++) begin
      chk("rst_no_rvalid", {d_rvalid, i_rvalid}, 2'b00);
      idle();
    end

    // Four contended cycles: grant order, fetch-slot overflow, sticky err
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(4'hF, 4'h0, 32'h180 + 32'(4 * k), 32'h0, 1'b1, 32'h280 + 32'(4 * k));
      chk("seq_en", ram_en, 1);
      chk("seq_addr", ram_addr, exp_seq[k]);
    end
    idle();
    chk("seq_en", ram_en, 1);
    chk("seq_addr", ram_addr, exp_seq[4]);
    chk("ovf_err", err, 1);
    repeat (LAT + 3) idle();
    chk("ovf_err_sticky", err, 1);
    chk("ovf_idle_busy", {d_busy, i_busy}, 2'b00);

    // Random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [3:0]  dr, dw;
      logic        ir;
      if (n == 1500) do_reset();
      dr = 4'h0; dw = 4'h0;
      if ($urandom_range(0, 99) < 45) begin
        if ($urandom_range(0, 1) == 1) dr = 4'($urandom_range(1, 15));
        else                           dw = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 299) == 0) begin
          dr = 4'hF; dw = 4'($urandom_range(1, 15));
        end
      end
      ir = ($urandom_range(0, 99) < 45);
      cycle(dr, dw, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom, ir,
            {22'd0, 8'($urandom_range(0, 255)), 2'b00});
    end
    repeat (LAT + 3) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares one synchronous data-RAM port between the memory stage's data requester (d_*) and the instruction-fetch requester (i_*).
- Both requesters issue single-cycle request pulses. The block buffers a losing request, issues requests to the RAM through registered outputs, and tracks in-flight reads with a latency-matched tag pipe.
- Each read response is routed back to its owner.
- Sits between the MEM/IF request logic and the shared RAM macro.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte strobes are DATA_W/8 (4 at default)
RAM_LAT, 1, RAM read latency in cycles from ram_en to ram_rdata valid; legal range 1..4

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
d_ren  in  4  data read strobe pulse; nonzero means read request
d_wen  in  4  data byte-write-enable pulse; nonzero means write request
d_addr  in  ADDR_W  data word address, already word-aligned
d_wdata  in  DATA_W  data write data
d_busy  out  1  data slot holds an un-issued request
d_rvalid  out  1  data read data valid
d_rdata  out  DATA_W  data read data
d_wdone  out  1  data write issued to RAM
i_req  in  1  fetch request pulse
i_addr  in  ADDR_W  fetch word address
i_busy  out  1  fetch slot holds an un-issued request
i_rvalid  out  1  fetch read data valid
i_rdata  out  DATA_W  fetch read data
ram_en  out  1  RAM access enable, registered
ram_we  out  4  RAM byte write enables, registered
ram_addr  out  ADDR_W  RAM address, registered
ram_wdata  out  DATA_W  RAM write data, registered
ram_rdata  in  DATA_W  RAM read data
err  out  1  sticky protocol error flag

Behaviour:
- Reset (rstn low, asynchronous): every output is 0 and both slots are empty. The tag pipe and round-robin pointer are cleared. In-flight reads are discarded and produce no rvalid after reset.
- Request capture: a data request exists when d_ren != 0 or d_wen != 0. If both are nonzero, it is treated as a write (ram_we = d_wen) and err is set.
- Candidates each cycle: per requester, the held slot if full, otherwise the incoming pulse.
- Arbitration: when both requesters have a candidate, the default policy is fixed priority, data wins. The granted candidate drives ram_* at the next edge.
- Issue latency: an uncontended pulse in cycle t gives ram_en=1 in cycle t+1.
- Losing pulse: stored in its slot, and busy goes high from cycle t+1. The slot is issued when granted; busy falls in the cycle its ram_en is high.
- New pulse while the own slot is full: the pulse is dropped, the slot is unchanged and err is set.
- Idle cycle: ram_en=0 and ram_we=0. ram_addr and ram_wdata hold their previous values.
- Write: ram_we = d_wen with ram_en=1. d_wdone pulses 1 in the same cycle. No tag is pushed.
- Read: ram_we=0 with ram_en=1. A tag {valid, owner} is pushed into a RAM_LAT-deep shift pipe.
- Read return: when a tag exits the pipe (cycle issue+RAM_LAT), the owner's rvalid=1 for exactly one cycle. The owner's rdata = ram_rdata in that cycle; the other requester's rdata is 0.
- Throughput: one access per cycle, with back-to-back reads fully pipelined. Both rvalids are never high together.
- err clears only on reset.

Optional Feature:
ARB_RR_EN
- Defined: on contention, the grant alternates between requesters. A last-grant register is updated on every grant, and the first contention after reset goes to data. No requester waits more than one grant.
- Undefined: fixed data priority, as described in Behaviour.

Test Plan:
- Uncontended data read: d_ren=F, d_addr=0x100 at t -> ram_en=1, ram_we=0, ram_addr=0x100 at t+1; d_rvalid=1 with d_rdata=RAM[0x100] at t+1+RAM_LAT; i_rvalid stays 0.
- Data write: d_wen=3, d_wdata=0xDEADBEEF, d_addr=0x40 at t -> ram_we=3 and d_wdone=1 at t+1; no d_rvalid follows.
- Simultaneous pulses: i_req with i_addr=0x8 and d_ren=F with d_addr=0x20 at t.
  - Without ARB_RR_EN: ram_addr=0x20 at t+1 and 0x8 at t+2; i_busy=1 only at t+1.
  - Routing: d_rvalid at t+1+RAM_LAT, then i_rvalid at t+2+RAM_LAT, each carrying its own address's data.
- Slot overflow: hold the fetch slot full under repeated data contention and pulse i_req again -> the second fetch is dropped, err=1 and stays 1; the original fetch is issued later.
- Round robin (ARB_RR_EN): contend in 4 consecutive cycles -> grants alternate D,I,D,I.
- Reset mid-read: assert rstn=0 one cycle after ram_en for a read -> all outputs 0; no rvalid after release.
